// File: rtl/fifo_buffer_match.sv
// Synchronous FIFO with per-port content lookup over the valid entries.
// Optional empty-bypass is enabled by defining FIFO_BYPASS_EN.
module fifo_buffer_match #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFF_DEPTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int RLAT_WIDTH  = 32,
  parameter int MATCH_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              flush,
  input  logic                              wen,
  input  logic                              ren,
  input  logic [DATA_WIDTH-1:0]             input_data,
  input  logic [MATCH_PORTS*RLAT_WIDTH-1:0] related_data,
  output logic [DATA_WIDTH-1:0]             output_data,
  output logic                              empty,
  output logic                              full,
  output logic [ADDR_WIDTH:0]               count,
  output logic [MATCH_PORTS-1:0]            related
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(BUFF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(BUFF_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] buff_q [BUFF_DEPTH];
  logic [DATA_WIDTH-1:0] buff_d [BUFF_DEPTH];
  logic [BUFF_DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic do_read_s;
  logic do_write_s;
  logic bypass_s;
  logic [MATCH_PORTS-1:0] hit_s;

  // Wrapping increment so non-power-of-two depths use exactly BUFF_DEPTH slots.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == LAST_IDX) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + PTR_ONE;
    end
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;

  // Handshake qualification, including the optional empty-bypass case.
  always_comb begin
    do_read_s = ren && !empty;
`ifdef FIFO_BYPASS_EN
    bypass_s   = empty && wen && ren && !flush;
    do_write_s = wen && (!full || do_read_s) && !bypass_s;
`else
    bypass_s   = 1'b0;
    do_write_s = wen && (!full || do_read_s);
`endif
  end

  // Head-of-queue data; bypassed word takes precedence when enabled.
  always_comb begin
    if (bypass_s) begin
      output_data = input_data;
    end else if (empty) begin
      output_data = '0;
    end else begin
      output_data = buff_q[tail_q];
    end
  end

  // Lookup compares registered state only, so same-cycle writes are not seen.
  always_comb begin
    hit_s = '0;
    for (int p = 0; p < MATCH_PORTS; p++) begin
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        if (valid_q[i] && (buff_q[i][RLAT_WIDTH-1:0] == related_data[p*RLAT_WIDTH +: RLAT_WIDTH])) begin
          hit_s[p] = 1'b1;
        end else begin
          hit_s[p] = hit_s[p];
        end
      end
    end
  end

  assign related = hit_s;

  // Next-state: read clears the tail slot before the write fills head, which
  // matters when full and both pointers name the same slot.
  always_comb begin
    buff_d  = buff_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        buff_d[i] = '0;
      end
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_read_s) begin
        buff_d[tail_q]  = '0;
        valid_d[tail_q] = 1'b0;
        tail_d          = next_ptr(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (do_write_s) begin
        buff_d[head_q]  = input_data;
        valid_d[head_q] = 1'b1;
        head_d          = next_ptr(head_q);
      end else begin
        head_d = head_q;
      end
      case ({do_write_s, do_read_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        buff_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        buff_q[i] <= buff_d[i];
      end
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
